// File: rtl/audio_tone_sequencer_if.sv
// audio_tone_sequencer_if: control, tone table and sample bus of the tone sequencer
interface audio_tone_sequencer_if #(
  parameter int DAC_WIDTH   = 8,
  parameter int PHASE_WIDTH = 24,
  parameter int NUM_TONES   = 3,
  parameter int IDX_WIDTH   = 2
);
  logic                             start;
  logic                             abort;
  logic [1:0]                       mode;
  logic [2:0]                       volume;
  logic [NUM_TONES*PHASE_WIDTH-1:0] tone_inc;
  logic [DAC_WIDTH-1:0]             audio_out;
  logic                             busy;
  logic                             done;
  logic [IDX_WIDTH-1:0]             tone_idx;
  modport master (output start, abort, mode, volume, tone_inc, input audio_out, busy, done, tone_idx);
  modport slave  (input start, abort, mode, volume, tone_inc, output audio_out, busy, done, tone_idx);
endinterface

// File: rtl/audio_tone_sequencer.sv
// audio_tone_sequencer: DDS tone generator playing a latched sequence of tones separated by silent gaps
module audio_tone_sequencer #(
  parameter int DAC_WIDTH   = 8,
  parameter int PHASE_WIDTH = 24,
  parameter int NUM_TONES   = 3,
  parameter int IDX_WIDTH   = 2,
  parameter int TONE_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 2500000,
  parameter int CNT_WIDTH   = 26
) (
  input logic CLOCK_50,
  input logic reset,
  audio_tone_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, TONE, GAP, FIN} state_t;
  state_t state;
  logic [PHASE_WIDTH-1:0] inc_sh [NUM_TONES];
  logic [PHASE_WIDTH-1:0] phase, inc;
  logic [1:0] mode_sh;
  logic [2:0] vol_sh;
  logic [CNT_WIDTH-1:0] cnt;
  logic [IDX_WIDTH-1:0] idx;
  logic [DAC_WIDTH-1:0] p, p2, wave, audio;
  logic busy, done, tone_end, gap_end, last;
  assign inc      = inc_sh[idx];
  assign p        = phase[PHASE_WIDTH-1 -: DAC_WIDTH];
  assign p2       = {p[DAC_WIDTH-2:0], 1'b0};
  assign tone_end = cnt == CNT_WIDTH'(TONE_CYCLES - 1);
  assign gap_end  = cnt == CNT_WIDTH'(GAP_CYCLES - 1);
  assign last     = idx == IDX_WIDTH'(NUM_TONES - 1);
  always_comb
    wave = mode_sh == 2'd0 ? (p[DAC_WIDTH-1] ? '0 : '1) :
           mode_sh == 2'd1 ? p :
           mode_sh == 2'd2 ? (p[DAC_WIDTH-1] ? ~p2 : p2) :
                             (p[DAC_WIDTH-1 -: 2] == 2'b00 ? '1 : '0);
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= '0;
      cnt     <= '0;
      idx     <= '0;
      audio   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      mode_sh <= '0;
      vol_sh  <= '0;
      for (int i = 0; i < NUM_TONES; i++) inc_sh[i] <= '0;
    end else if (bus.abort) begin
      state <= IDLE;
      audio <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done  <= 1'b0;
      audio <= (state == TONE && inc != '0) ? wave >> vol_sh : '0;
      case (state)
        IDLE: if (bus.start) begin
          state   <= TONE;
          busy    <= 1'b1;
          phase   <= '0;
          cnt     <= '0;
          idx     <= '0;
          mode_sh <= bus.mode;
          vol_sh  <= bus.volume;
          for (int i = 0; i < NUM_TONES; i++) inc_sh[i] <= bus.tone_inc[i*PHASE_WIDTH +: PHASE_WIDTH];
        end
        TONE: if (tone_end) begin
          cnt   <= '0;
          phase <= '0;
          if (last) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (GAP_CYCLES == 0) idx <= idx + 1'b1;
          else state <= GAP;
        end else begin
          cnt   <= cnt + 1'b1;
          phase <= phase + inc;
        end
        GAP: if (gap_end) begin
          cnt   <= '0;
          idx   <= idx + 1'b1;
          state <= TONE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.audio_out = audio;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.tone_idx  = idx;
endmodule

// File: tb/tb_audio_tone_sequencer.sv
// tb_audio_tone_sequencer: scoreboard bench for the tone sequencer, with and without inter-tone gaps
module tb_audio_tone_sequencer;
  logic CLOCK_50 = 1'b0;
  logic reset, start, abort, sel;
  logic [1:0] mode;
  logic [2:0] volume;
  logic [23:0] tone_inc;
  int checks = 0, errors = 0, busy_cnt, done_cnt;
  typedef struct {int audio; int busy; int done; int idx;} exp_t;
  exp_t q[$];
  always #5 CLOCK_50 = ~CLOCK_50;
  audio_tone_sequencer_if #(.DAC_WIDTH(4), .PHASE_WIDTH(8), .NUM_TONES(3), .IDX_WIDTH(2)) i0 ();
  audio_tone_sequencer_if #(.DAC_WIDTH(4), .PHASE_WIDTH(8), .NUM_TONES(3), .IDX_WIDTH(2)) i1 ();
  assign i0.start = start & ~sel;
  assign i1.start = start & sel;
  assign i0.abort = abort;
  assign i1.abort = abort;
  assign i0.mode = mode;
  assign i1.mode = mode;
  assign i0.volume = volume;
  assign i1.volume = volume;
  assign i0.tone_inc = tone_inc;
  assign i1.tone_inc = tone_inc;
  audio_tone_sequencer #(.DAC_WIDTH(4), .PHASE_WIDTH(8), .NUM_TONES(3), .IDX_WIDTH(2),
    .TONE_CYCLES(16), .GAP_CYCLES(4)) d0 (.CLOCK_50(CLOCK_50), .reset(reset), .bus(i0.slave));
  audio_tone_sequencer #(.DAC_WIDTH(4), .PHASE_WIDTH(8), .NUM_TONES(3), .IDX_WIDTH(2),
    .TONE_CYCLES(16), .GAP_CYCLES(0)) d1 (.CLOCK_50(CLOCK_50), .reset(reset), .bus(i1.slave));
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic int samp(int md, int vl, int inc, int off);
    int p = ((off * inc) % 256) / 16;
    int w = md == 0 ? (p < 8 ? 15 : 0) : md == 1 ? p :
            md == 2 ? (p < 8 ? (2 * p) % 16 : 15 - (2 * p) % 16) : (p < 4 ? 15 : 0);
    return inc == 0 ? 0 : w >> vl;
  endfunction
  task automatic tick;
    exp_t e;
    logic [3:0] a;
    logic b, d;
    logic [1:0] ix;
    @(posedge CLOCK_50);
    #1;
    a  = sel ? i1.audio_out : i0.audio_out;
    b  = sel ? i1.busy : i0.busy;
    d  = sel ? i1.done : i0.done;
    ix = sel ? i1.tone_idx : i0.tone_idx;
    busy_cnt += int'(b);
    done_cnt += int'(d);
    if (q.size() != 0) begin
      e = q.pop_front();
      check("audio_out", 32'(a), e.audio);
      check("busy", 32'(b), e.busy);
      check("done", 32'(d), e.done);
      check("tone_idx", 32'(ix), e.idx);
    end
  endtask
  task automatic run(int n);
    repeat (n) tick();
  endtask
  task automatic push_idle(int idx, int n);
    exp_t e;
    e = '{0, 0, 0, idx};
    repeat (n) q.push_back(e);
  endtask
  task automatic push_seq(int gap);
    int b = 48 + 2 * gap, seg = 16 + gap, k;
    logic [23:0] ti = tone_inc;
    exp_t e;
    for (int j = 0; j <= b + 1; j++) begin
      k = j - 1;
      e.busy  = int'(j < b);
      e.done  = int'(j == b);
      e.idx   = j < b ? j / seg : 2;
      e.audio = (j == 0 || k >= b || k % seg >= 16) ? 0 :
                samp(int'(mode), int'(volume), int'(ti[8*(k/seg) +: 8]), k % seg);
      q.push_back(e);
    end
  endtask
  task automatic go(int gap);
    busy_cnt = 0;
    done_cnt = 0;
    push_seq(gap);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; sel = 1'b0;
    mode = 2'd0; volume = 3'd0; tone_inc = '0;
    run(3);
    reset = 1'b0;
    push_idle(0, 20);
    run(20);
    mode = 2'd1; volume = 3'd0; tone_inc = {8'd16, 8'd32, 8'd16};
    go(4);
    for (int j = 1; j <= 57; j++) begin
      tick();
      start = (j == 29) || (j == 56);
    end
    check("busy_len", busy_cnt, 56);
    check("done_pulses", done_cnt, 1);
    push_idle(2, 2);
    run(2);
    mode = 2'd0; volume = 3'd1; tone_inc = {8'd8, 8'd8, 8'd64};
    go(4);
    run(57);
    volume = 3'd4;
    go(4);
    run(57);
    sel = 1'b1;
    mode = 2'd1; volume = 3'd0; tone_inc = {8'd32, 8'd0, 8'd16};
    go(0);
    run(49);
    check("busy_len_nogap", busy_cnt, 48);
    check("done_nogap", done_cnt, 1);
    sel = 1'b0;
    tone_inc = {8'd16, 8'd32, 8'd16};
    go(4);
    run(20);
    abort = 1'b1;
    q.delete();
    push_idle(1, 1);
    tick();
    abort = 1'b0;
    push_idle(1, 4);
    run(4);
    check("abort_no_done", done_cnt, 0);
    start = 1'b1; abort = 1'b1;
    push_idle(1, 1);
    tick();
    start = 1'b0; abort = 1'b0;
    push_idle(1, 3);
    run(3);
    mode = 2'd2; volume = 3'd1; tone_inc = {8'd48, 8'd16, 8'd80};
    go(4);
    run(10);
    mode = 2'd3; volume = 3'd0; tone_inc = '1;
    run(47);
    go(4);
    run(10);
    reset = 1'b1;
    q.delete();
    push_idle(0, 1);
    tick();
    reset = 1'b0;
    push_idle(0, 3);
    run(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_tone_sequencer.md
Name: audio_tone_sequencer

Overview:
Parametrised successor to the fixed single-frequency square-wave audio block. It is a phase-accumulator (DDS) tone generator with a multi-bit DAC output, four selectable waveforms, volume scaling, and a built-in sequencer. The sequencer plays NUM_TONES tones back to back, separated by silent gaps, with a start/busy/done handshake. It sits in the DE0-Nano top level and drives a GPIO resistor-ladder DAC for robot audio cues (e.g. start tone, treasure-found jingle).

Parameters:
DAC_WIDTH, 8, output sample width (>=2)
PHASE_WIDTH, 24, phase accumulator width (>=DAC_WIDTH)
NUM_TONES, 3, tones per sequence (>=1)
IDX_WIDTH, 2, tone_idx width; must be >= max(1,clog2(NUM_TONES))
TONE_CYCLES, 25000000, duration of each tone in CLOCK_50 cycles (>=1)
GAP_CYCLES, 2500000, silence between tones in cycles (0 = no gap)
CNT_WIDTH, 26, duration counter width; must hold max(TONE_CYCLES,GAP_CYCLES)

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high
start  input  1  request playback; sampled only in IDLE
abort  input  1  stop playback immediately
mode  input  2  waveform: 00 square 50%, 01 sawtooth, 10 triangle, 11 pulse 25%
volume  input  3  attenuation; sample right-shifted by volume (0 = full)
tone_inc  input  NUM_TONES*PHASE_WIDTH  phase increment per tone; tone i at [i*PHASE_WIDTH +: PHASE_WIDTH]; tone 0 plays first
audio_out  output  DAC_WIDTH  unsigned DAC sample
busy  output  1  high while in TONE or GAP
done  output  1  one-cycle pulse when a sequence completes normally
tone_idx  output  IDX_WIDTH  index of the current or most recent tone

Behaviour:
- Clock and reset: clock CLOCK_50; reset is synchronous, active-high. On reset: state IDLE, audio_out=0, busy=0, done=0, tone_idx=0, phase=0, counter=0. Reset mid-sequence behaves the same way; no done pulse is produced.
- States: IDLE, TONE, GAP, FIN.
- IDLE -> TONE on start=1 (and abort=0).
  - At that edge: latch tone_inc, mode and volume into shadow registers; later input changes have no effect until the next start.
  - Set phase=0, counter=0, tone_idx=0.
- TONE:
  - Each cycle: phase <= phase + inc[tone_idx], modulo 2^PHASE_WIDTH (wraps silently).
  - counter increments. At counter==TONE_CYCLES-1: clear counter and phase.
    - If tone_idx==NUM_TONES-1 -> FIN.
    - Else if GAP_CYCLES==0 -> tone_idx+1 and stay in TONE.
    - Else -> GAP.
- GAP: silent. At counter==GAP_CYCLES-1: clear counter, tone_idx+1, -> TONE.
- FIN: lasts one cycle; done=1, busy=0; -> IDLE. tone_idx holds NUM_TONES-1 until the next start.
- busy is a registered state decode: high exactly in TONE and GAP.
  - Busy duration = NUM_TONES*TONE_CYCLES + (NUM_TONES-1)*GAP_CYCLES cycles.
  - busy rises the cycle after start is sampled.
- Waveform: let p = phase[PHASE_WIDTH-1 -: DAC_WIDTH] and MAX = all ones.
  - square: p MSB==0 ? MAX : 0
  - sawtooth: p
  - triangle: p MSB==0 ? (p<<1) : ~(p<<1), truncated to DAC_WIDTH
  - pulse: top two bits of p ==00 ? MAX : 0
- Output sample: wave >> volume (logical shift).
  - audio_out is registered and lags the phase register by one cycle.
  - audio_out=0 in IDLE, GAP and FIN, and during any tone whose latched inc==0 (rest).
  - volume >= DAC_WIDTH yields 0.
- start while busy: ignored, including in FIN.
- abort: from any state, next state is IDLE, with audio_out=0 and busy=0 on the next cycle and no done pulse. In IDLE, abort and start together means abort wins and the block stays in IDLE.
- No combinational path from any input to any output.

Test Plan:
Bench parameters for all scenarios: PHASE_WIDTH=8, DAC_WIDTH=4, NUM_TONES=3, TONE_CYCLES=16, GAP_CYCLES=4.
1. Reset, idle hold: hold start=0 for 20 cycles -> audio_out=0, busy=0, done=0, tone_idx=0 throughout.
2. Full sawtooth sequence: mode=01, volume=0, inc={8'd16,8'd32,8'd16}, pulse start.
   - busy high exactly 56 cycles.
   - Tone 0 audio_out steps 0,1,2,...,15; tone 1 steps by 2.
   - Each GAP: 4 cycles of 0, with tone_idx 0->1->2.
   - done high one cycle immediately after busy falls.
3. Square and volume: mode=00, volume=1, inc[0]=64 -> tone 0 audio_out repeats 7,7,0,0 (MAX>>1=7). With volume=4 -> all zeros.
4. Rest tone and no-gap: rebuild with GAP_CYCLES=0, inc[1]=0 -> busy exactly 48 cycles; audio_out=0 for all 16 cycles of tone 1; tone_idx advances with no silent gap.
5. Abort and retrigger: abort at busy cycle 20 -> busy=0 and audio_out=0 next cycle, no done pulse. start asserted during busy is ignored. start together with abort in IDLE -> stays IDLE.
6. Shadow latching: change tone_inc, mode and volume mid-sequence -> output matches the values latched at start. Reset asserted mid-tone -> all outputs return to reset values on the next cycle.
